pipe_hazard_ctrl: RTL and testbench

//  Hazard/stall controller for the 5-stage MIPS pipeline. Drives the F/D freeze, the PC

---
 rtl/pipe_hazard_ctrl_if.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 74 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline hazard controller and the datapath.
// The datapath side (master) drives the decode/execute/memory status inputs.
`timescale 1ns/1ps
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       D_rs;
  logic [4:0]       D_rt;
  logic [1:0]       D_tuse_rs;
  logic [1:0]       D_tuse_rt;
  logic             D_is_md;
  logic [4:0]       E_wa;
  logic [1:0]       E_tnew;
  logic [4:0]       M_wa;
  logic [1:0]       M_tnew;
  logic             E_md_start;
  logic             E_md_div;
  logic             pc_we;
  logic             D_we;
  logic             E_clr;
  logic             md_busy;
  logic             md_done;
  logic             md_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
    output E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
    input  pc_we, D_we, E_clr, md_busy, md_done, md_err, stall_cnt
  );

  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
    input  E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
    output pc_we, D_we, E_clr, md_busy, md_done, md_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: data-hazard and
// mult/div stalls, mult/div busy countdown, saturating stall-cycle counter.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 32
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int unsigned MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned MD_W   = $clog2(MD_MAX + 1);
  localparam logic [MD_W-1:0] MULT_LD = MD_W'(MULT_CYC);
  localparam logic [MD_W-1:0] DIV_LD  = MD_W'(DIV_CYC);
  localparam logic [MD_W-1:0] MD_ONE  = MD_W'(1);

  logic [MD_W-1:0]  md_cnt;
  logic             md_err_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             md_busy;
  logic             stall_rs;
  logic             stall_rt;
  logic             stall_md;
  logic             stall;

  assign md_busy = (md_cnt != '0);

  // A producer only blocks D when its result arrives later than D needs it.
  always_comb begin
    stall_rs = (hz.D_rs != '0) &&
               (((hz.E_wa == hz.D_rs) && (hz.E_tnew > hz.D_tuse_rs)) ||
                ((hz.M_wa == hz.D_rs) && (hz.M_tnew > hz.D_tuse_rs)));
    stall_rt = (hz.D_rt != '0) &&
               (((hz.E_wa == hz.D_rt) && (hz.E_tnew > hz.D_tuse_rt)) ||
                ((hz.M_wa == hz.D_rt) && (hz.M_tnew > hz.D_tuse_rt)));
    stall_md = hz.D_is_md && (md_busy || hz.E_md_start);
    stall    = stall_rs || stall_rt || stall_md;
  end

  // A start while the unit is busy is dropped and flagged; the running op finishes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt   <= '0;
      md_err_q <= 1'b0;
    end else begin
      if (hz.E_md_start && !md_busy) begin
        md_cnt <= hz.E_md_div ? DIV_LD : MULT_LD;
      end else if (md_busy) begin
        md_cnt <= md_cnt - MD_ONE;
      end
      if (hz.E_md_start && md_busy) begin
        md_err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hz.pc_we     = ~stall;
  assign hz.D_we      = ~stall;
  assign hz.E_clr     = stall;
  assign hz.md_busy   = md_busy;
  assign hz.md_done   = (md_cnt == MD_ONE);
  assign hz.md_err    = md_err_q;
  assign hz.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, directed mult/div sequences and
// random traffic against a cycle-indexed reference model.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;
  logic clk;
  logic reset;

  pipe_hazard_ctrl_if #(.CNT_W(32)) hz ();
  pipe_hazard_ctrl_if #(.CNT_W(3))  hz3 ();

  pipe_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .hz(hz)
  );
  pipe_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .hz(hz3)
  );

  assign hz3.D_rs       = hz.D_rs;
  assign hz3.D_rt       = hz.D_rt;
  assign hz3.D_tuse_rs  = hz.D_tuse_rs;
  assign hz3.D_tuse_rt  = hz.D_tuse_rt;
  assign hz3.D_is_md    = hz.D_is_md;
  assign hz3.E_wa       = hz.E_wa;
  assign hz3.E_tnew     = hz.E_tnew;
  assign hz3.M_wa       = hz.M_wa;
  assign hz3.M_tnew     = hz.M_tnew;
  assign hz3.E_md_start = hz.E_md_start;
  assign hz3.E_md_div   = hz.E_md_div;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: cycle index since reset, index of last busy cycle of the
  // accepted op, sticky error flag, and an unbounded stall count.
  int cur    = 0;
  int md_end = -1;
  bit m_err  = 0;
  int scnt   = 0;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [4:0] e_wa;
    logic [1:0] e_tnew;
    logic [4:0] m_wa;
    logic [1:0] m_tnew;
    logic       exp_stall;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit m_busy();
    return cur <= md_end;
  endfunction

  function automatic bit m_stall();
    bit s = 0;
    logic [4:0] r;
    logic [1:0] tu;
    for (int op = 0; op < 2; op++) begin
      r  = (op == 0) ? hz.D_rs : hz.D_rt;
      tu = (op == 0) ? hz.D_tuse_rs : hz.D_tuse_rt;
      if (r != 0) begin
        if (hz.E_wa == r && int'(hz.E_tnew) > int'(tu)) s = 1;
        if (hz.M_wa == r && int'(hz.M_tnew) > int'(tu)) s = 1;
      end
    end
    if (hz.D_is_md && (m_busy() || hz.E_md_start)) s = 1;
    return s;
  endfunction

  task automatic model_clear();
    cur = 0; md_end = -1; m_err = 0; scnt = 0;
  endtask

  task automatic model_edge();
    bit was_busy;
    if (m_stall()) scnt++;
    was_busy = m_busy();
    cur++;
    if (hz.E_md_start) begin
      if (was_busy) m_err = 1;
      else md_end = cur + (hz.E_md_div ? 10 : 5) - 1;
    end
  endtask

  task automatic check_all();
    bit s = m_stall();
    chk("pc_we", hz.pc_we, !s);
    chk("D_we", hz.D_we, !s);
    chk("E_clr", hz.E_clr, s);
    chk("md_busy", hz.md_busy, m_busy());
    chk("md_done", hz.md_done, cur == md_end);
    chk("md_err", hz.md_err, m_err);
    chk("stall_cnt", hz.stall_cnt, scnt);
    chk("stall_cnt3", 32'(hz3.stall_cnt), (scnt > 7) ? 7 : scnt);
  endtask

  task automatic half_a();
    @(negedge clk);
    check_all();
  endtask

  task automatic half_b();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    hz.D_rs = 0; hz.D_rt = 0; hz.D_tuse_rs = 0; hz.D_tuse_rt = 0; hz.D_is_md = 0;
    hz.E_wa = 0; hz.E_tnew = 0; hz.M_wa = 0; hz.M_tnew = 0;
    hz.E_md_start = 0; hz.E_md_div = 0;
  endtask

  // Called at posedge+1; reset is asynchronous so outputs clear within the cycle.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_clear();
    chk("rst_busy", hz.md_busy, 0);
    chk("rst_done", hz.md_done, 0);
    chk("rst_err", hz.md_err, 0);
    chk("rst_scnt", hz.stall_cnt, 0);
    chk("rst_scnt3", 32'(hz3.stall_cnt), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    hz.D_rs = v.rs; hz.D_rt = v.rt; hz.D_tuse_rs = v.tuse_rs; hz.D_tuse_rt = v.tuse_rt;
    hz.E_wa = v.e_wa; hz.E_tnew = v.e_tnew; hz.M_wa = v.m_wa; hz.M_tnew = v.m_tnew;
    hz.D_is_md = 0; hz.E_md_start = 0; hz.E_md_div = 0;
  endtask

  initial begin
    tbl[0] = '{5'd8, 5'd0, 2'd0, 2'd3, 5'd8, 2'd1, 5'd0, 2'd0, 1'b1};
    tbl[1] = '{5'd0, 5'd0, 2'd0, 2'd3, 5'd0, 2'd1, 5'd0, 2'd0, 1'b0};
    tbl[2] = '{5'd0, 5'd9, 2'd3, 2'd0, 5'd0, 2'd0, 5'd9, 2'd1, 1'b1};
    tbl[3] = '{5'd0, 5'd9, 2'd3, 2'd1, 5'd0, 2'd0, 5'd9, 2'd1, 1'b0};
    tbl[4] = '{5'd8, 5'd0, 2'd1, 2'd3, 5'd8, 2'd2, 5'd0, 2'd0, 1'b1};
    tbl[5] = '{5'd8, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0};
    tbl[6] = '{5'd5, 5'd0, 2'd0, 2'd3, 5'd6, 2'd2, 5'd0, 2'd0, 1'b0};
    tbl[7] = '{5'd0, 5'd7, 2'd3, 2'd1, 5'd7, 2'd1, 5'd7, 2'd2, 1'b1};

    reset = 1'b1;
    set_idle();
    @(posedge clk);
    #1;
    do_reset();
    half_a();
    chk("idle_pc_we", hz.pc_we, 1);
    chk("idle_E_clr", hz.E_clr, 0);
    half_b();

    for (int i = 0; i < 8; i++) begin
      apply_vec(tbl[i]);
      half_a();
      chk($sformatf("tbl%0d_E_clr", i), hz.E_clr, tbl[i].exp_stall);
      chk($sformatf("tbl%0d_pc_we", i), hz.pc_we, !tbl[i].exp_stall);
      half_b();
    end

    // mult with a HI/LO user waiting in D: start cycle plus 5 busy cycles stall
    set_idle();
    do_reset();
    hz.D_is_md = 1; hz.E_md_start = 1; hz.E_md_div = 0;
    half_a();
    chk("mult_start_stall", hz.E_clr, 1);
    half_b();
    hz.E_md_start = 0;
    for (int k = 1; k <= 5; k++) begin
      half_a();
      chk("mult_busy", hz.md_busy, 1);
      chk("mult_done", hz.md_done, k == 5);
      chk("mult_stall", hz.E_clr, 1);
      half_b();
    end
    half_a();
    chk("mult_idle", hz.md_busy, 0);
    chk("mult_release", hz.E_clr, 0);
    chk("mult_scnt", hz.stall_cnt, 6);
    half_b();

    // div with a conflicting start 3 cycles in: flagged, length unchanged
    set_idle();
    hz.E_md_start = 1; hz.E_md_div = 1;
    half_a(); half_b();
    hz.E_md_start = 0;
    for (int k = 1; k <= 10; k++) begin
      hz.E_md_start = (k == 3);
      hz.E_md_div = 0;
      half_a();
      chk("div_busy", hz.md_busy, 1);
      chk("div_done", hz.md_done, k == 10);
      half_b();
    end
    hz.E_md_start = 0;
    half_a();
    chk("div_idle", hz.md_busy, 0);
    chk("div_err", hz.md_err, 1);
    half_b();

    // reset in cycle 4 of a div aborts it with no done pulse
    hz.E_md_start = 1; hz.E_md_div = 1;
    half_a(); half_b();
    hz.E_md_start = 0;
    for (int k = 1; k <= 3; k++) begin
      half_a(); half_b();
    end
    do_reset();
    half_a();
    chk("abort_busy", hz.md_busy, 0);
    chk("abort_done", hz.md_done, 0);
    half_b();

    // start in the done cycle conflicts; start in the following cycle loads
    hz.E_md_start = 1; hz.E_md_div = 0;
    half_a(); half_b();
    for (int k = 1; k <= 5; k++) begin
      hz.E_md_start = (k == 5);
      half_a(); half_b();
    end
    hz.E_md_start = 1;
    half_a();
    chk("b2b_idle", hz.md_busy, 0);
    chk("b2b_err", hz.md_err, 1);
    half_b();
    hz.E_md_start = 0;
    half_a();
    chk("b2b_reload", hz.md_busy, 1);
    half_b();
    for (int k = 0; k < 5; k++) begin
      half_a(); half_b();
    end

    // saturation of the narrow counter
    set_idle();
    do_reset();
    apply_vec(tbl[0]);
    for (int k = 0; k < 10; k++) begin
      half_a(); half_b();
    end
    half_a();
    chk("sat_scnt3", 32'(hz3.stall_cnt), 7);
    chk("sat_scnt", hz.stall_cnt, 10);
    half_b();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      hz.D_rs = 5'($urandom_range(0, 3));
      hz.D_rt = 5'($urandom_range(0, 3));
      hz.D_tuse_rs = 2'($urandom_range(0, 3));
      hz.D_tuse_rt = 2'($urandom_range(0, 3));
      hz.D_is_md = 1'($urandom_range(0, 1));
      hz.E_wa = 5'($urandom_range(0, 3));
      hz.E_tnew = 2'($urandom_range(0, 3));
      hz.M_wa = 5'($urandom_range(0, 3));
      hz.M_tnew = 2'($urandom_range(0, 3));
      hz.E_md_start = ($urandom_range(0, 5) == 0);
      hz.E_md_div = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 149) == 0) do_reset();
      half_a();
      half_b();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
